// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and arbiter types for the framebuffer memory path.
package fb_pkg;

    localparam int unsigned FB_W           = 320;
    localparam int unsigned FB_H           = 200;
    localparam int unsigned FB_PAGES       = 2;
    localparam int unsigned FB_TOTAL_BYTES = FB_PAGES * FB_W * FB_H;
    localparam int unsigned FB_ADDR_W      = $clog2(FB_TOTAL_BYTES);

    typedef enum logic {
        ARB_VID_PRI  = 1'b0,
        ARB_CPU_TURN = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_VID = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// Bundles the scanout port, CPU port and BRAM port of the framebuffer arbiter.
interface fb_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 8
);

    logic              vid_req_i;
    logic              vid_urgent_i;
    logic [ADDR_W-1:0] vid_addr_i;
    logic              vid_gnt_o;
    logic              vid_rvalid_o;
    logic [DATA_W-1:0] vid_rdata_o;

    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic              cpu_gnt_o;
    logic              cpu_rvalid_o;
    logic [DATA_W-1:0] cpu_rdata_o;

    logic              err_o;

    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Arbiter side.
    modport slave (
        input  vid_req_i, vid_urgent_i, vid_addr_i,
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  mem_rdata_i,
        output vid_gnt_o, vid_rvalid_o, vid_rdata_o,
        output cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        output err_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    // Requesters and BRAM side.
    modport master (
        output vid_req_i, vid_urgent_i, vid_addr_i,
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output mem_rdata_i,
        input  vid_gnt_o, vid_rvalid_o, vid_rdata_o,
        input  cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o,
        input  err_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/fb_arb_pick.sv
// Combinational winner select: urgent video, then a forced CPU turn, then video, then CPU.
module fb_arb_pick
    import fb_pkg::*;
(
    input  logic       vid_req_i,
    input  logic       vid_urgent_i,
    input  logic       cpu_req_i,
    input  arb_state_e state_i,
    output logic       vid_win_o,
    output logic       cpu_win_o
);

    always_comb begin
        vid_win_o = 1'b0;
        cpu_win_o = 1'b0;
        if (vid_req_i && vid_urgent_i) begin
            vid_win_o = 1'b1;
        end else if (state_i == ARB_CPU_TURN && cpu_req_i) begin
            cpu_win_o = 1'b1;
        end else if (vid_req_i) begin
            vid_win_o = 1'b1;
        end else if (cpu_req_i) begin
            cpu_win_o = 1'b1;
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Single-port framebuffer BRAM arbiter between scanout reads and CPU loads/stores,
// with a bounded video run to guarantee CPU progress and 1-cycle read latency.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W         = fb_pkg::FB_ADDR_W,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned FB_TOTAL_BYTES = fb_pkg::FB_TOTAL_BYTES,
    parameter int unsigned MAX_VID_RUN    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    fb_mem_arbiter_if.slave   bus
);

    localparam int unsigned     CntW      = $clog2(MAX_VID_RUN + 1);
    localparam logic [CntW-1:0] MaxRun    = CntW'(MAX_VID_RUN);
    localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'(FB_TOTAL_BYTES);

    arb_state_e        state_q;
    logic [CntW-1:0]   run_cnt_q, run_cnt_d;
    owner_e            owner_q;
    logic              rd_q;
    logic              err_q;

    logic              pick_vid, pick_cpu;
    logic              vid_gnt, cpu_gnt, gnt_any;
    logic [ADDR_W-1:0] win_addr;
    logic              win_oor;
    logic              win_rd;

    fb_arb_pick u_pick (
        .vid_req_i    (bus.vid_req_i),
        .vid_urgent_i (bus.vid_urgent_i),
        .cpu_req_i    (bus.cpu_req_i),
        .state_i      (state_q),
        .vid_win_o    (pick_vid),
        .cpu_win_o    (pick_cpu)
    );

    // Grants are forced low while reset is asserted.
    always_comb begin
        vid_gnt  = pick_vid & rst_ni;
        cpu_gnt  = pick_cpu & rst_ni;
        gnt_any  = vid_gnt | cpu_gnt;
        win_addr = cpu_gnt ? bus.cpu_addr_i : bus.vid_addr_i;
        win_oor  = gnt_any && ({1'b0, win_addr} >= AddrLimit);
        win_rd   = vid_gnt | (cpu_gnt & ~bus.cpu_we_i);

        bus.vid_gnt_o   = vid_gnt;
        bus.cpu_gnt_o   = cpu_gnt;
        bus.mem_en_o    = gnt_any & ~win_oor;
        bus.mem_we_o    = cpu_gnt & bus.cpu_we_i & ~win_oor;
        bus.mem_addr_o  = gnt_any ? win_addr : '0;
        bus.mem_wdata_o = cpu_gnt ? bus.cpu_wdata_i : '0;
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (!bus.cpu_req_i || cpu_gnt) begin
            run_cnt_d = '0;
        end else if (vid_gnt && run_cnt_q != MaxRun) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_VID_PRI;
            run_cnt_q <= '0;
            owner_q   <= OWN_VID;
            rd_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            run_cnt_q <= run_cnt_d;
            owner_q   <= cpu_gnt ? OWN_CPU : OWN_VID;
            rd_q      <= win_rd;
            err_q     <= win_oor;
            unique case (state_q)
                ARB_VID_PRI: begin
                    if (run_cnt_d == MaxRun) state_q <= ARB_CPU_TURN;
                end
                ARB_CPU_TURN: begin
                    // Urgent video may keep winning; the turn is held until the CPU is served.
                    if (cpu_gnt || !bus.cpu_req_i) state_q <= ARB_VID_PRI;
                end
            endcase
        end
    end

    // BRAM data arrives in the response cycle, so rdata is steered by the registered tags.
    always_comb begin
        bus.vid_rvalid_o = rd_q && (owner_q == OWN_VID);
        bus.cpu_rvalid_o = rd_q && (owner_q == OWN_CPU);
        bus.err_o        = err_q;
        bus.vid_rdata_o  = (bus.vid_rvalid_o && !err_q) ? bus.mem_rdata_i : '0;
        bus.cpu_rdata_o  = (bus.cpu_rvalid_o && !err_q) ? bus.mem_rdata_i : '0;
    end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with a BRAM model and a response scoreboard.
module tb_fb_mem_arbiter;

    localparam int unsigned AW    = 17;
    localparam int unsigned DW    = 8;
    localparam int          TOTAL = 128000;

    typedef struct packed {
        logic       vrv;
        logic       crv;
        logic       err;
        logic [7:0] data;
    } resp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_mem_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .FB_TOTAL_BYTES (TOTAL),
        .MAX_VID_RUN    (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    logic [7:0] bram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_en_o) begin
            if (bus.mem_we_o) bram[bus.mem_addr_o] <= bus.mem_wdata_o;
            else              bus.mem_rdata_i <= bram[bus.mem_addr_o];
        end
    end

    resp_t      sb [$];
    logic [7:0] shadow [int];
    int         checks   = 0;
    int         failures = 0;

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a * 7 + 3);
    endfunction

    function automatic logic [7:0] exp_byte(input int a);
        if (shadow.exists(a)) return shadow[a];
        return init_byte(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One arbitration cycle, entered at a negedge with inputs already driven.
    // exp_g: 0 = no grant, 1 = video, 2 = CPU.
    task automatic cyc(input int exp_g, input string tag);
        resp_t r;
        int    a;
        logic  in_rng;
        #1;
        chk({tag, ".vgnt"}, 32'(bus.vid_gnt_o), 32'(exp_g == 1));
        chk({tag, ".cgnt"}, 32'(bus.cpu_gnt_o), 32'(exp_g == 2));
        r = '0;
        if (exp_g != 0) begin
            a      = (exp_g == 1) ? int'(bus.vid_addr_i) : int'(bus.cpu_addr_i);
            in_rng = (a < TOTAL);
            r.err  = ~in_rng;
            chk({tag, ".en"}, 32'(bus.mem_en_o), 32'(in_rng));
            if (in_rng) chk({tag, ".addr"}, 32'(bus.mem_addr_o), 32'(a));
            if (exp_g == 1) begin
                r.vrv  = 1'b1;
                r.data = in_rng ? exp_byte(a) : 8'h00;
            end else if (!bus.cpu_we_i) begin
                r.crv  = 1'b1;
                r.data = in_rng ? exp_byte(a) : 8'h00;
                chk({tag, ".we"}, 32'(bus.mem_we_o), 32'(0));
            end else begin
                chk({tag, ".we"}, 32'(bus.mem_we_o), 32'(in_rng));
                if (in_rng) shadow[a] = bus.cpu_wdata_i;
            end
        end else begin
            chk({tag, ".en"}, 32'(bus.mem_en_o), 32'(0));
        end
        sb.push_back(r);
        @(posedge clk);
        #1;
        r = sb.pop_front();
        chk({tag, ".vrv"},   32'(bus.vid_rvalid_o), 32'(r.vrv));
        chk({tag, ".crv"},   32'(bus.cpu_rvalid_o), 32'(r.crv));
        chk({tag, ".err"},   32'(bus.err_o),        32'(r.err));
        chk({tag, ".vdata"}, 32'(bus.vid_rdata_o),  32'(r.vrv ? r.data : 8'h00));
        chk({tag, ".cdata"}, 32'(bus.cpu_rdata_o),  32'(r.crv ? r.data : 8'h00));
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".vgnt"},  32'(bus.vid_gnt_o),    32'(0));
        chk({tag, ".cgnt"},  32'(bus.cpu_gnt_o),    32'(0));
        chk({tag, ".en"},    32'(bus.mem_en_o),     32'(0));
        chk({tag, ".we"},    32'(bus.mem_we_o),     32'(0));
        chk({tag, ".vrv"},   32'(bus.vid_rvalid_o), 32'(0));
        chk({tag, ".crv"},   32'(bus.cpu_rvalid_o), 32'(0));
        chk({tag, ".err"},   32'(bus.err_o),        32'(0));
        chk({tag, ".vdata"}, 32'(bus.vid_rdata_o),  32'(0));
        chk({tag, ".cdata"}, 32'(bus.cpu_rdata_o),  32'(0));
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) bram[i] = init_byte(i);
        bram[16]   = 8'h5A;
        shadow[16] = 8'h5A;

        bus.vid_req_i    = 1'b1;
        bus.vid_urgent_i = 1'b0;
        bus.vid_addr_i   = '0;
        bus.cpu_req_i    = 1'b1;
        bus.cpu_we_i     = 1'b0;
        bus.cpu_addr_i   = '0;
        bus.cpu_wdata_i  = '0;

        // Reset with both requests high: everything must stay quiet.
        repeat (2) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        bus.vid_req_i = 1'b0;
        bus.cpu_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Video-only read.
        bus.vid_req_i  = 1'b1;
        bus.vid_addr_i = 17'h00010;
        cyc(1, "vid_rd");
        bus.vid_req_i = 1'b0;
        cyc(0, "idle");

        // CPU write then read back.
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = 1'b1;
        bus.cpu_addr_i  = 17'd64000;
        bus.cpu_wdata_i = 8'hC3;
        cyc(2, "cpu_wr");
        bus.cpu_we_i = 1'b0;
        cyc(2, "cpu_rd");
        bus.cpu_req_i = 1'b0;
        chk("cpu_rd.c3", 32'(exp_byte(64000)), 32'h0C3);

        // Both requesting continuously: V,V,V,V,C repeating.
        bus.vid_addr_i = 17'h00100;
        bus.cpu_addr_i = 17'h00200;
        bus.vid_req_i  = 1'b1;
        bus.cpu_req_i  = 1'b1;
        for (int i = 0; i < 15; i++) cyc((i % 5 == 4) ? 2 : 1, "rr");

        // Reach the CPU turn, then hold it off with urgent video.
        for (int i = 0; i < 4; i++) cyc(1, "pre_urg");
        bus.vid_urgent_i = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1, "urg");
        bus.vid_urgent_i = 1'b0;
        cyc(2, "post_urg");
        cyc(1, "after_urg");
        bus.vid_req_i = 1'b0;
        bus.cpu_req_i = 1'b0;
        cyc(0, "idle_urg");

        // Out-of-range read and write, then the last valid byte.
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 17'd128000;
        cyc(2, "oor_rd");
        bus.cpu_we_i    = 1'b1;
        bus.cpu_addr_i  = 17'd130000;
        bus.cpu_wdata_i = 8'h77;
        cyc(2, "oor_wr");
        chk("oor_wr.bram", 32'(bram[130000]), 32'(init_byte(130000)));
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 17'd127999;
        cyc(2, "last_rd");
        bus.cpu_req_i = 1'b0;
        cyc(0, "idle_oor");

        // Reset lands between a video read grant and its response.
        bus.vid_req_i  = 1'b1;
        bus.vid_addr_i = 17'h00010;
        #1;
        chk("rst_fly.vgnt", 32'(bus.vid_gnt_o), 32'(1));
        #2;
        rst_n         = 1'b0;
        bus.cpu_req_i = 1'b1;
        @(posedge clk);
        #1;
        chk_idle_outputs("rst_fly");
        @(negedge clk);
        rst_n = 1'b1;

        // After release the arbiter starts in the video-priority state.
        for (int i = 0; i < 5; i++) cyc((i == 4) ? 2 : 1, "post_rst");
        bus.vid_req_i = 1'b0;
        bus.cpu_req_i = 1'b0;
        cyc(0, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
Shares the single-port framebuffer BRAM (2 pages × 320×200 × 8bpp = 128000 bytes) between two requesters: the display scanout read path and the CPU load/store path. Scanout has priority, and an urgent input overrides everything. A bounded-run counter guarantees CPU forward progress. The block sits between the framebuffer controller's read side, the CPU bus bridge and the BRAM macro, and returns read data with fixed 1-cycle latency.

Parameters:
ADDR_W, 17, byte address width into the framebuffer BRAM
DATA_W, 8, data width (one 8bpp pixel index)
FB_TOTAL_BYTES, 128000, valid address range [0, FB_TOTAL_BYTES-1]
MAX_VID_RUN, 4, consecutive video grants allowed while the CPU waits before the CPU is forced a turn (≥1)

Ports:
clk_i  in  1  single clock
rst_ni  in  1  asynchronous active-low reset
vid_req_i  in  1  scanout read request
vid_urgent_i  in  1  scanout pixel FIFO below low-water; video must win
vid_addr_i  in  ADDR_W  scanout byte address
vid_gnt_o  out  1  video request accepted this cycle (combinational)
vid_rvalid_o  out  1  video read data valid
vid_rdata_o  out  DATA_W  video read data
cpu_req_i  in  1  CPU access request
cpu_we_i  in  1  1 = write, 0 = read
cpu_addr_i  in  ADDR_W  CPU byte address
cpu_wdata_i  in  DATA_W  CPU write data
cpu_gnt_o  out  1  CPU request accepted this cycle (combinational)
cpu_rvalid_o  out  1  CPU read data valid (reads only)
cpu_rdata_o  out  DATA_W  CPU read data
err_o  out  1  one-cycle pulse: the access granted last cycle was out of range
mem_en_o  out  1  BRAM enable
mem_we_o  out  1  BRAM write enable
mem_addr_o  out  ADDR_W  BRAM address
mem_wdata_o  out  DATA_W  BRAM write data
mem_rdata_i  in  DATA_W  BRAM read data, valid 1 cycle after mem_en_o with mem_we_o=0

Behaviour:
- At most one grant per cycle. A grant cycle is the BRAM command cycle: mem_* are driven combinationally from the winner.
- Requesters hold req, addr, we and wdata stable until gnt. The arbiter does not latch requests.
- States ARB_VID_PRI (reset) and ARB_CPU_TURN.
- Winner selection, in priority order:
  1. vid_req_i & vid_urgent_i → video.
  2. State ARB_CPU_TURN & cpu_req_i → CPU.
  3. vid_req_i → video.
  4. cpu_req_i → CPU.
  5. Otherwise no grant; mem_en_o=0.
- run_cnt (width clog2(MAX_VID_RUN+1)):
  - Increments, saturating at MAX_VID_RUN, on a video grant while cpu_req_i=1.
  - Clears on a CPU grant or any cycle with cpu_req_i=0.
- Transitions:
  - ARB_VID_PRI→ARB_CPU_TURN when run_cnt reaches MAX_VID_RUN; the next cycle is ARB_CPU_TURN.
  - ARB_CPU_TURN→ARB_VID_PRI on a CPU grant, or when cpu_req_i drops.
- Urgent video in ARB_CPU_TURN still wins; the state is held and the CPU wins at the first non-urgent cycle.
- Out of range (addr ≥ FB_TOTAL_BYTES):
  - The request is still granted; mem_en_o=0 and mem_we_o=0.
  - Next cycle err_o=1. For a read, the owner's rvalid=1 with rdata=0. A write is dropped.
- Response pipeline: owner/is-read/oor tags are registered on the grant cycle. The next cycle asserts exactly one of vid_rvalid_o/cpu_rvalid_o for reads, with rdata = mem_rdata_i (or 0 if oor). The non-owner's rdata is 0.
- CPU writes are complete on grant: no rvalid.
- Back-to-back grants are sustained every cycle (throughput 1/cycle).
- Reset: state=ARB_VID_PRI, run_cnt=0, tags cleared. All registered outputs (vid_rvalid_o, cpu_rvalid_o, vid_rdata_o, cpu_rdata_o, err_o) are 0. Combinational outputs are 0 while rst_ni=0. A read in flight when reset asserts is dropped and no rvalid follows.

Decomposition:
- fb_pkg holds:
  - FB_W, FB_H, FB_TOTAL_BYTES, FB_ADDR_W
  - typedef enum arb_state_e {ARB_VID_PRI, ARB_CPU_TURN}
  - typedef enum logic owner_e {OWN_VID, OWN_CPU}
- Sub-module fb_arb_pick: pure combinational winner select from (req, urgent, state).
- Counter, FSM, tag pipeline and memory muxing stay in fb_mem_arbiter.

Test Plan:
- Video-only read at addr 0x00010 with BRAM holding 0x5A → vid_gnt_o same cycle, vid_rvalid_o=1 with rdata 0x5A next cycle; cpu_rvalid_o stays 0.
- CPU write 0xC3 to 64000, then CPU read of 64000 → both granted in consecutive cycles; cpu_rvalid_o one cycle after the read grant with 0xC3.
- vid_req_i and cpu_req_i held high continuously, MAX_VID_RUN=4 → grant pattern V,V,V,V,C repeating; the CPU wait never exceeds 4 cycles.
- Same as above with vid_urgent_i=1 for 10 cycles → 10 straight video grants, state ARB_CPU_TURN held; the CPU is granted on the first cycle after urgent drops.
- CPU read at 128000 → cpu_gnt_o=1, mem_en_o=0; next cycle err_o=1, cpu_rvalid_o=1, rdata 0x00. A CPU write at 130000 leaves BRAM unchanged.
- Assert rst_ni low on the cycle after a video read grant → no vid_rvalid_o, all outputs 0, state ARB_VID_PRI after release.
